// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, control FSM states and the flag bundle.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
// done pulses during the final iteration; product holds the accumulator until the next start.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             w_last;

  assign w_last  = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign busy    = r_busy;
  assign done    = w_last;
  assign product = r_acc;

  // Latch operands on start, then add/shift once per cycle until the last bit is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_b_sh[0]) begin
        r_acc <= r_acc + r_a_sh;
      end
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides and a single registered result/flag stage.
// Single-cycle ops load the output register at the accept edge; MUL runs in alu_mul_seq and
// hands its product over through the BUSY/DONE states.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_load_single;
  logic             w_load_mul;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  assign w_accept      = in_valid && in_ready;
  assign w_is_mul      = (MUL_EN != 0) && (op == OP_MUL);
  assign w_mul_start   = w_accept && w_is_mul;
  assign w_load_single = w_accept && !w_is_mul;

  if (MUL_EN != 0) begin : g_mul
    alu_mul_seq #(
      .WIDTH (WIDTH)
    ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (w_mul_start),
      .a       (a),
      .b       (b),
      .busy    (w_mul_busy),
      .done    (w_mul_done),
      .product (w_mul_product)
    );
  end else begin : g_no_mul
    assign w_mul_busy    = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
  end

  // SUB reuses the adder as a + ~b + 1, so carry means "no borrow".
  assign w_sub   = (op == OP_SUB);
  assign w_b_eff = w_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
  assign w_shamt = b[SHW-1:0];

  // Combinational op mux for the single-cycle ops; undefined codes produce zero.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  w_res = a << w_shamt;
      OP_SRL:  w_res = a >> w_shamt;
      OP_SRA:  w_res = $signed(a) >>> w_shamt;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: w_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_mul_start) w_state_next = BUSY;
      // Leaving BUSY without a running multiplier is only a recovery path.
      BUSY: begin
        if (w_mul_done) begin
          w_state_next = DONE;
        end else if (!w_mul_busy) begin
          w_state_next = IDLE;
        end
      end
      DONE: if (w_load_mul) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: issue gating and the product handoff into the output register.
  always_comb begin
    in_ready   = !rst && (r_state == IDLE) && (!r_out_valid || out_ready);
    w_load_mul = (r_state == DONE) && (!r_out_valid || out_ready);
  end

  // Output register: load on single-cycle accept or MUL handoff, clear valid on bare consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_load_single) begin
      r_out_valid   <= 1'b1;
      r_result      <= w_res;
      r_flags.zero  <= (w_res == '0);
      r_flags.neg   <= w_res[WIDTH-1];
      r_flags.carry <= w_carry;
      r_flags.ovf   <= w_ovf;
    end else if (w_load_mul) begin
      r_out_valid   <= 1'b1;
      r_result      <= w_mul_product;
      r_flags.zero  <= (w_mul_product == '0);
      r_flags.neg   <= w_mul_product[WIDTH-1];
      r_flags.carry <= 1'b0;
      r_flags.ovf   <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_flags.zero;
  assign neg       = r_flags.neg;
  assign carry     = r_flags.carry;
  assign ovf       = r_flags.ovf;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the 3-bit-opcode ALU, with configurable datapath width and a valid/ready handshake on both sides.
- Results and a full flag set (zero, negative, carry, overflow) leave through a single registered output stage.
- Adds signed/unsigned set-less-than and an iterative shift-add multiplier.
- Sits between the decode/operand-fetch stage and writeback; backpressure from writeback stalls issue.

Parameters:
- WIDTH, 32: datapath width in bits; must be >= 4 and a power of two.
- MUL_EN, 1: 1 includes the iterative multiplier; 0 makes op MUL behave as an undefined op.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shifts use b[$clog2(WIDTH)-1:0] only.
- op  in  4  operation code.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- carry  out  1  ADD: carry-out. SUB: 1 iff a >= b unsigned (no borrow). All other ops: 0.
- ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.

Behaviour:
- Ops: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT (signed), 9 SLTU, 10 MUL (low WIDTH bits of the product).
- Ops 11-15 are undefined: result 0, zero 1, all other flags 0.
- SLT and SLTU return 1 or 0, zero-extended.
- Reset, and any cycle with rst high:
  - out_valid=0, result=0, all flags 0, FSM to IDLE, multiplier counter cleared.
  - in_ready=0.
  - Reset mid-multiply aborts the operation with no output.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - result and flags are held stable while out_valid && !out_ready.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready).
- Single-cycle ops:
  - Computed combinationally and loaded into the output register at the accept edge; out_valid=1 the next cycle (latency 1).
  - Simultaneous consume and accept replaces the register and keeps out_valid=1, giving throughput of 1 per cycle.
  - Consume without accept clears out_valid.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept op MUL (MUL_EN=1) -> BUSY. Latch a and b, clear the accumulator, counter=0. out_valid/result are not loaded by this accept; any previous result consumed that cycle clears out_valid.
  - BUSY: each cycle, if b_shift[0] then acc += a_shift; a_shift <<= 1; b_shift >>= 1; counter++. After WIDTH iterations (counter==WIDTH-1 edge) -> DONE.
  - DONE: if !out_valid || out_ready, load acc into result, set out_valid, go to IDLE. Otherwise stay in DONE holding acc.
  - in_ready=0 in BUSY and DONE.
- MUL latency is WIDTH+1 cycles from the accept edge to out_valid when unstalled (33 for WIDTH=32).
- Arithmetic:
  - Addition uses a WIDTH+1 bit sum; SUB is a + ~b + 1 with the same carry rule.
  - ovf = (sa==sb_eff) && (sr!=sa), where sb_eff is the sign of b for ADD and of ~b for SUB.
  - SRA replicates a[WIDTH-1].
  - Shift amounts of 0 pass a through unchanged.

Decomposition:
- Package alu_pkg:
  - alu_op_e: 4-bit enum of the op codes above.
  - alu_state_e: IDLE/BUSY/DONE.
  - Flag struct alu_flags_t {zero, neg, carry, ovf}.
- Sub-module alu_mul_seq (WIDTH parameter, start/busy/done/product ports) holds the iterative shift-add multiplier. The top level owns the FSM-to-output-register handoff and the combinational op mux.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, neg=1, ovf=1, carry=0, zero=0; out_valid exactly 1 cycle after accept.
- SUB a=b=0x12345678 -> result 0, zero=1, carry=1, ovf=0. Also SLT a=0xFFFFFFFF b=1 -> 1, and SLTU on the same operands -> 0.
- SRA a=0xFFFFFFF0 b=0x00000024 (shift amount 4) -> 0xFFFFFFFF; SRL on the same operands -> 0x0FFFFFFF; SLL a=0x7FFFFFFF b=1 -> 0xFFFFFFFE.
- MUL a=0x00010001 b=0x00010001 -> 0x00020001; out_valid exactly 33 cycles after accept; in_ready=0 throughout; a second in_valid held during BUSY is accepted only after completion.
- Backpressure: out_ready=0, then issue AND 0x0000FFFF & 0x00FFFF00 -> 0x0000FF00 held stable, in_ready=0. Raising out_ready with a pending OR gives the next-cycle result 0x00FFFFFF with no bubble.
- Reset at cycle 10 of a MUL -> out_valid=0, result=0, flags 0; in_ready=1 the first cycle after rst falls; the next ADD 2+3 returns 5.
